mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/cpu_bus_pkg.sv | 8 +
 rtl/mem_resp_ram.sv | 16 +
 rtl/mem_responder.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared state encoding and bus constants for the CPU memory responder
package cpu_bus_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam logic [4:0] RAM_PAGE_DEF = 5'h18;
    localparam logic [7:0] PROT_BOUND = 8'h80;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: 256x8 RAM, one synchronous write port, asynchronous read, contents survive reset
module mem_resp_ram
    import cpu_bus_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [7:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [7:0]        i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [256];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: CPU bus responder with wait states, one RAM page and miss/conflict errors
// Optional low-half write protect is enabled by defining MEM_RESPONDER_WRPROT_EN
module mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int         WAIT_CYCLES = 0,
    parameter logic [4:0] RAM_PAGE    = RAM_PAGE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              ready,
    output logic              err
);
    localparam logic [2:0] LOAD = 3'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    state_t            r_state, w_next;
    logic              r_rd_q, r_wr_q, r_armed, r_rd_lat, r_wr_lat;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, w_rdata;
    logic              w_start, w_abort, w_hit, w_prot, w_rd_acc, w_wr_acc, w_we;
    // r_armed blocks a strobe that was already high when reset released
    assign w_start  = r_state == S_IDLE && r_armed && !r_rd_q && !r_wr_q && (rd || wr);
    assign w_abort  = (r_rd_lat && !rd) || (r_wr_lat && !wr);
    assign w_hit    = r_addr[12:8] == RAM_PAGE;
    assign w_rd_acc = r_rd_lat && !r_wr_lat;
    assign w_wr_acc = r_wr_lat && !r_rd_lat;
`ifdef MEM_RESPONDER_WRPROT_EN
    assign w_prot   = w_wr_acc && w_hit && r_addr[7:0] < PROT_BOUND;
`else
    assign w_prot   = 1'b0;
`endif
    assign w_we     = r_state == S_RESP && w_wr_acc && w_hit && !w_prot;
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= S_IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (w_abort) w_next = S_IDLE; else if (r_cnt == 3'd0) w_next = S_RESP;
            S_RESP:  w_next = S_HOLD;
            S_HOLD:  if (!rd && !wr) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        ready    = r_state == S_RESP;
        err      = ready && (!(w_rd_acc || w_wr_acc) || !w_hit || w_prot);
        data_oe  = (r_state == S_RESP || r_state == S_HOLD) && w_rd_acc && !wr;
        data_out = (data_oe && w_hit) ? w_rdata : '0;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_rd_q   <= 1'b0;
            r_wr_q   <= 1'b0;
            r_armed  <= 1'b0;
            r_rd_lat <= 1'b0;
            r_wr_lat <= 1'b0;
            r_cnt    <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_rd_q <= rd;
            r_wr_q <= wr;
            if (!rd && !wr) r_armed <= 1'b1;
            if (w_start) begin
                r_addr   <= addr;
                r_rd_lat <= rd;
                r_wr_lat <= wr;
                r_wdata  <= data_in;
                r_cnt    <= LOAD;
            end else if (r_state == S_WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
    mem_resp_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr[7:0]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[7:0]),
        .o_rdata (w_rdata)
    );
endmodule
